// File: rtl/nonogram_pkg.sv
// Shared types and constants for the nonogram board controller.
// Key bit positions match the key_pulse bus layout.
package nonogram_pkg;

    localparam int DEF_N = 10;
    localparam int NKEYS = 5;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ACT   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_FLASH,
        S_DEAD,
        S_DONE
    } state_t;

endpackage

// File: rtl/nonogram_board_ctrl_if.sv
// Player-input bundle between the key/level source and the board controller.
// Master drives keys and level data; slave returns cursor, grids and status.
interface nonogram_board_ctrl_if #(
    parameter int N = 10
);
    logic [4:0]     key_pulse;
    logic           mode;
    logic           load;
    logic [N*N-1:0] solution;
    logic [3:0]     sel_x;
    logic [3:0]     sel_y;
    logic [N*N-1:0] paint;
    logic [N*N-1:0] block;
    logic [4:0]     wrong_count;
    logic           event_off;
    logic           flash;
    logic           dead;
    logic           solved;

    modport master (
        output key_pulse, mode, load, solution,
        input  sel_x, sel_y, paint, block, wrong_count,
        input  event_off, flash, dead, solved
    );

    modport slave (
        input  key_pulse, mode, load, solution,
        output sel_x, sel_y, paint, block, wrong_count,
        output event_off, flash, dead, solved
    );
endinterface

// File: rtl/nonogram_key_arbiter.sv
// Fixed-priority pick of one key pulse per cycle.
// Order: act > up > down > left > right.
module nonogram_key_arbiter
    import nonogram_pkg::*;
(
    input  logic [NKEYS-1:0] i_key,
    output logic [NKEYS-1:0] o_grant,
    output logic             o_valid
);

    always_comb begin
        o_grant = '0;
        if (i_key[KEY_ACT]) begin
            o_grant[KEY_ACT] = 1'b1;
        end else if (i_key[KEY_UP]) begin
            o_grant[KEY_UP] = 1'b1;
        end else if (i_key[KEY_DOWN]) begin
            o_grant[KEY_DOWN] = 1'b1;
        end else if (i_key[KEY_LEFT]) begin
            o_grant[KEY_LEFT] = 1'b1;
        end else if (i_key[KEY_RIGHT]) begin
            o_grant[KEY_RIGHT] = 1'b1;
        end
    end

    assign o_valid = |i_key;

endmodule

// File: rtl/nonogram_board_ctrl.sv
// Nonogram player-input stage: cursor, paint/block grids, wrong-attempt
// tracking with error flash, lockout and solved detection.
module nonogram_board_ctrl
    import nonogram_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int MAX_WRONG    = 5,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    nonogram_board_ctrl_if.slave bus
);

    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int CW    = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);
    localparam logic [3:0]    LAST       = 4'(N - 1);
    localparam logic [4:0]    WMAX       = 5'(MAX_WRONG);

    state_t           r_state;
    logic [3:0]       r_sel_x;
    logic [3:0]       r_sel_y;
    logic [CELLS-1:0] r_paint;
    logic [CELLS-1:0] r_block;
    logic [4:0]       r_wrong;
    logic             r_event_off;
    logic             r_flash;
    logic             r_dead;
    logic             r_solved;
    logic             r_match;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;

    logic [NKEYS-1:0] w_grant;
    logic             w_valid;
    logic [IW-1:0]    w_cell;
    logic [CELLS-1:0] w_paint_hit;
    logic [4:0]       w_wrong_inc;

    nonogram_key_arbiter u_arb (
        .i_key   (bus.key_pulse),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_cell      = IW'(int'(r_sel_y) * N + int'(r_sel_x));
    assign w_paint_hit = CELLS'(1) << r_idx;
    assign w_wrong_inc = (r_wrong >= WMAX) ? r_wrong : r_wrong + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel_x     <= '0;
            r_sel_y     <= '0;
            r_paint     <= '0;
            r_block     <= '0;
            r_wrong     <= '0;
            r_event_off <= 1'b0;
            r_flash     <= 1'b0;
            r_dead      <= 1'b0;
            r_solved    <= 1'b0;
            r_match     <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else if (bus.load) begin
            r_state     <= S_IDLE;
            r_sel_x     <= '0;
            r_sel_y     <= '0;
            r_paint     <= '0;
            r_block     <= '0;
            r_wrong     <= '0;
            r_event_off <= 1'b0;
            r_flash     <= 1'b0;
            r_dead      <= 1'b0;
            r_solved    <= 1'b0;
            r_match     <= ~|bus.solution;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else begin
            r_event_off <= 1'b0;
            r_match     <= (r_paint == bus.solution);
            unique case (r_state)
                S_IDLE: begin
                    if (r_match) begin
                        r_state  <= S_DONE;
                        r_solved <= 1'b1;
                    end else if (w_valid) begin
                        unique case (1'b1)
                            w_grant[KEY_ACT]: begin
                                if (bus.mode) begin
                                    if (!r_paint[w_cell])
                                        r_block[w_cell] <= ~r_block[w_cell];
                                end else if (!r_paint[w_cell] &&
                                             !r_block[w_cell]) begin
                                    r_idx   <= w_cell;
                                    r_state <= S_EVAL;
                                end
                            end
                            w_grant[KEY_UP]:
                                r_sel_y <= (r_sel_y == 4'd0) ? LAST
                                                             : r_sel_y - 4'd1;
                            w_grant[KEY_DOWN]:
                                r_sel_y <= (r_sel_y == LAST) ? 4'd0
                                                             : r_sel_y + 4'd1;
                            w_grant[KEY_LEFT]:
                                r_sel_x <= (r_sel_x == 4'd0) ? LAST
                                                             : r_sel_x - 4'd1;
                            w_grant[KEY_RIGHT]:
                                r_sel_x <= (r_sel_x == LAST) ? 4'd0
                                                             : r_sel_x + 4'd1;
                            default: ;
                        endcase
                    end
                end
                S_EVAL: begin
                    if (bus.solution[r_idx]) begin
                        r_paint[r_idx] <= 1'b1;
                        // keep the compare in step with the paint just written
                        r_match <= ((r_paint | w_paint_hit) == bus.solution);
                        r_state <= S_IDLE;
                    end else begin
                        r_block[r_idx] <= 1'b1;
                        r_wrong        <= w_wrong_inc;
                        r_event_off    <= 1'b1;
                        r_flash        <= 1'b1;
                        r_cnt          <= FLASH_LAST;
                        r_state        <= S_FLASH;
                    end
                end
                S_FLASH: begin
                    if (r_cnt == '0) begin
                        r_flash <= 1'b0;
                        if (r_wrong == WMAX) begin
                            r_dead  <= 1'b1;
                            r_state <= S_DEAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DEAD, S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sel_x       = r_sel_x;
    assign bus.sel_y       = r_sel_y;
    assign bus.paint       = r_paint;
    assign bus.block       = r_block;
    assign bus.wrong_count = r_wrong;
    assign bus.event_off   = r_event_off;
    assign bus.flash       = r_flash;
    assign bus.dead        = r_dead;
    assign bus.solved      = r_solved;

endmodule

// File: tb/tb_nonogram_board_ctrl.sv
// Directed bench for nonogram_board_ctrl: cursor, paint/block, flash,
// lockout, solved detection and load priority.
module tb_nonogram_board_ctrl;

    localparam int N  = 10;
    localparam int MW = 2;
    localparam int FC = 4;

    localparam logic [N*N-1:0] SOL = (100'h1) | (100'h1 << 12);

    localparam logic [4:0] K_UP    = 5'b00001;
    localparam logic [4:0] K_DOWN  = 5'b00010;
    localparam logic [4:0] K_LEFT  = 5'b00100;
    localparam logic [4:0] K_RIGHT = 5'b01000;
    localparam logic [4:0] K_ACT   = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    nonogram_board_ctrl_if #(.N(N)) bus ();

    nonogram_board_ctrl #(
        .N            (N),
        .MAX_WRONG    (MW),
        .FLASH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        bus.key_pulse = k;
        step();
        bus.key_pulse = '0;
    endtask

    task automatic do_load();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        bus.key_pulse = '0;
        bus.mode      = 1'b0;
        bus.load      = 1'b0;
        bus.solution  = SOL;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if (bus.sel_x !== 4'd0 || bus.sel_y !== 4'd0)
            $display("FAIL reset_cursor: got %0d,%0d want 0,0", bus.sel_x, bus.sel_y);
        else n_pass++;
        n_total++;
        if (bus.paint !== '0 || bus.block !== '0)
            $display("FAIL reset_grids: paint=%h block=%h want 0", bus.paint, bus.block);
        else n_pass++;
        n_total++;
        if (bus.wrong_count !== 5'd0)
            $display("FAIL reset_wrong: got %0d want 0", bus.wrong_count);
        else n_pass++;
        n_total++;
        if ({bus.event_off, bus.flash, bus.dead, bus.solved} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.event_off, bus.flash, bus.dead, bus.solved});
        else n_pass++;
        step();
        n_total++;
        if (bus.solved !== 1'b0)
            $display("FAIL reset_not_solved: got %b want 0", bus.solved);
        else n_pass++;
    endtask

    task automatic test_move();
        do_load();
        for (int i = 0; i < N; i++) begin
            press(K_RIGHT);
            n_total++;
            if (bus.sel_x !== 4'((i + 1) % N))
                $display("FAIL move_right[%0d]: got %0d want %0d", i, bus.sel_x, (i + 1) % N);
            else n_pass++;
        end
        press(K_UP);
        n_total++;
        if (bus.sel_y !== 4'd9)
            $display("FAIL move_up_wrap: got %0d want 9", bus.sel_y);
        else n_pass++;
        n_total++;
        if (bus.paint !== '0 || bus.block !== '0)
            $display("FAIL move_grids: paint=%h block=%h want 0", bus.paint, bus.block);
        else n_pass++;
        press(K_DOWN);
        n_total++;
        if (bus.sel_y !== 4'd0)
            $display("FAIL move_down_wrap: got %0d want 0", bus.sel_y);
        else n_pass++;
    endtask

    task automatic test_paint_ok();
        bus.mode = 1'b0;
        press(K_ACT);
        n_total++;
        if (bus.paint[0] !== 1'b0)
            $display("FAIL paint_early: got %b want 0", bus.paint[0]);
        else n_pass++;
        step();
        n_total++;
        if (bus.paint[0] !== 1'b1)
            $display("FAIL paint_ok: got %b want 1", bus.paint[0]);
        else n_pass++;
        n_total++;
        if (bus.event_off !== 1'b0 || bus.wrong_count !== 5'd0 || bus.block !== '0)
            $display("FAIL paint_ok_side: ev=%b wrong=%0d block=%h want 0,0,0",
                     bus.event_off, bus.wrong_count, bus.block);
        else n_pass++;
    endtask

    task automatic test_wrong();
        int fc;
        int ec;
        press(K_RIGHT);
        press(K_ACT);
        step();
        n_total++;
        if (bus.block[1] !== 1'b1 || bus.paint[1] !== 1'b0)
            $display("FAIL wrong_block: block1=%b paint1=%b want 1,0", bus.block[1], bus.paint[1]);
        else n_pass++;
        n_total++;
        if (bus.event_off !== 1'b1 || bus.flash !== 1'b1 || bus.wrong_count !== 5'd1)
            $display("FAIL wrong_flags: ev=%b flash=%b wrong=%0d want 1,1,1",
                     bus.event_off, bus.flash, bus.wrong_count);
        else n_pass++;
        fc = 1;
        ec = 1;
        for (int i = 0; i < 10 && bus.flash; i++) begin
            bus.key_pulse = K_RIGHT;
            step();
            if (bus.flash) fc++;
            if (bus.event_off) ec++;
        end
        bus.key_pulse = '0;
        n_total++;
        if (fc != FC)
            $display("FAIL flash_len: got %0d want %0d", fc, FC);
        else n_pass++;
        n_total++;
        if (ec != 1)
            $display("FAIL event_off_count: got %0d want 1", ec);
        else n_pass++;
        n_total++;
        if (bus.sel_x !== 4'd1 || bus.dead !== 1'b0)
            $display("FAIL flash_keys: sel_x=%0d dead=%b want 1,0", bus.sel_x, bus.dead);
        else n_pass++;
        press(K_ACT);
        step();
        n_total++;
        if (bus.wrong_count !== 5'd1 || bus.flash !== 1'b0 || bus.paint[1] !== 1'b0)
            $display("FAIL act_on_blocked: wrong=%0d flash=%b paint1=%b want 1,0,0",
                     bus.wrong_count, bus.flash, bus.paint[1]);
        else n_pass++;
    endtask

    task automatic test_dead();
        press(K_RIGHT);
        press(K_ACT);
        step();
        n_total++;
        if (bus.wrong_count !== 5'd2)
            $display("FAIL dead_wrong: got %0d want 2", bus.wrong_count);
        else n_pass++;
        for (int i = 0; i < 20 && bus.flash; i++) step();
        n_total++;
        if (bus.flash !== 1'b0 || bus.dead !== 1'b1)
            $display("FAIL dead_enter: flash=%b dead=%b want 0,1", bus.flash, bus.dead);
        else n_pass++;
        press(K_RIGHT);
        n_total++;
        if (bus.sel_x !== 4'd2 || bus.wrong_count !== 5'd2)
            $display("FAIL dead_keys: sel_x=%0d wrong=%0d want 2,2", bus.sel_x, bus.wrong_count);
        else n_pass++;
        do_load();
        n_total++;
        if (bus.sel_x !== 4'd0 || bus.paint !== '0 || bus.block !== '0 ||
            bus.wrong_count !== 5'd0 || bus.dead !== 1'b0)
            $display("FAIL dead_load: x=%0d paint=%h block=%h wrong=%0d dead=%b want all 0",
                     bus.sel_x, bus.paint, bus.block, bus.wrong_count, bus.dead);
        else n_pass++;
    endtask

    task automatic test_block();
        repeat (3) press(K_RIGHT);
        repeat (3) press(K_DOWN);
        bus.mode = 1'b1;
        press(K_ACT);
        n_total++;
        if (bus.block[33] !== 1'b1 || bus.paint !== '0)
            $display("FAIL block_set: block33=%b paint=%h want 1,0", bus.block[33], bus.paint);
        else n_pass++;
        press(K_ACT);
        n_total++;
        if (bus.block[33] !== 1'b0)
            $display("FAIL block_clear: got %b want 0", bus.block[33]);
        else n_pass++;
        repeat (3) press(K_LEFT);
        repeat (3) press(K_UP);
        bus.mode = 1'b0;
        press(K_ACT);
        step();
        bus.mode = 1'b1;
        press(K_ACT);
        n_total++;
        if (bus.paint !== 100'h1 || bus.block !== '0)
            $display("FAIL block_on_painted: paint=%h block=%h want 1,0", bus.paint, bus.block);
        else n_pass++;
        bus.mode = 1'b0;
    endtask

    task automatic test_solved();
        repeat (2) press(K_RIGHT);
        press(K_DOWN);
        press(K_ACT | K_RIGHT);
        n_total++;
        if (bus.sel_x !== 4'd2)
            $display("FAIL act_priority: sel_x=%0d want 2", bus.sel_x);
        else n_pass++;
        step();
        n_total++;
        if (bus.paint !== SOL || bus.solved !== 1'b0)
            $display("FAIL solve_paint: paint=%h solved=%b want %h,0", bus.paint, bus.solved, SOL);
        else n_pass++;
        step();
        n_total++;
        if (bus.solved !== 1'b1)
            $display("FAIL solved: got %b want 1", bus.solved);
        else n_pass++;
        press(K_LEFT);
        n_total++;
        if (bus.sel_x !== 4'd2 || bus.solved !== 1'b1)
            $display("FAIL solved_keys: sel_x=%0d solved=%b want 2,1", bus.sel_x, bus.solved);
        else n_pass++;
    endtask

    task automatic test_load_wins();
        bus.load      = 1'b1;
        bus.key_pulse = K_ACT;
        step();
        bus.load      = 1'b0;
        bus.key_pulse = '0;
        n_total++;
        if (bus.solved !== 1'b0 || bus.paint !== '0 || bus.sel_x !== 4'd0 || bus.sel_y !== 4'd0)
            $display("FAIL load_wins: solved=%b paint=%h x=%0d y=%0d want 0",
                     bus.solved, bus.paint, bus.sel_x, bus.sel_y);
        else n_pass++;
        step();
        step();
        n_total++;
        if (bus.paint !== '0 || bus.block !== '0 || bus.solved !== 1'b0)
            $display("FAIL load_drops_act: paint=%h block=%h solved=%b want 0",
                     bus.paint, bus.block, bus.solved);
        else n_pass++;
    endtask

    task automatic test_zero_solution();
        bus.solution = '0;
        do_load();
        n_total++;
        if (bus.solved !== 1'b0)
            $display("FAIL zero_sol_early: got %b want 0", bus.solved);
        else n_pass++;
        step();
        n_total++;
        if (bus.solved !== 1'b1)
            $display("FAIL zero_sol_done: got %b want 1", bus.solved);
        else n_pass++;
        bus.solution = SOL;
    endtask

    initial begin
        test_reset();
        test_move();
        test_paint_ok();
        test_wrong();
        test_dead();
        test_block();
        test_solved();
        test_load_wins();
        test_zero_solution();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
